// File: rtl/barcode_reader_if.sv
// Scanner-to-reader bundle for the parking-ticket barcode path.
// The scanner side drives the serial bits; the reader side returns the decoded ticket status.
interface barcode_reader_if;
  logic       ScanStart;
  logic       ScanValid;
  logic       ScanBit;
  logic [5:0] Code;
  logic       ClientA;
  logic       ClientB;
  logic [6:0] MinutesLeft;
  logic       Active;
  logic       Expired;
  logic       CodeError;
  logic       Busy;

  modport master (
    output ScanStart, ScanValid, ScanBit,
    input  Code, ClientA, ClientB, MinutesLeft, Active, Expired, CodeError, Busy
  );

  modport slave (
    input  ScanStart, ScanValid, ScanBit,
    output Code, ClientA, ClientB, MinutesLeft, Active, Expired, CodeError, Busy
  );
endinterface

// File: rtl/barcode_reader.sv
// Rebuilds the 6-bit ticket code from the scanner, validates it and runs the per-minute countdown.
// Define BARCODE_READER_PARITY_EN to reject frames whose even-parity bit [1] does not match.
module barcode_reader #(
  parameter int TICKS_PER_MIN = 60,
  parameter int BIT_TIMEOUT   = 255
) (
  input logic            Clk,
  input logic            Reset,
  barcode_reader_if.slave bus
);

  localparam int TKW = (TICKS_PER_MIN > 2) ? $clog2(TICKS_PER_MIN) : 1;
  localparam int TW  = (BIT_TIMEOUT > 1) ? $clog2(BIT_TIMEOUT + 1) : 1;
  localparam logic [TKW-1:0] TICK_LAST = TKW'(TICKS_PER_MIN - 1);
  localparam logic [TW-1:0]  TO_LAST   = TW'(BIT_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, SHIFT, CHECK, RUN, EXPIRED} state_t;

  state_t         state;
  logic [5:0]     shift_reg;
  logic [2:0]     bit_cnt;
  logic [TW-1:0]  timeout_cnt;
  logic [TKW-1:0] tick_cnt;
  logic [5:0]     code_q;
  logic           client_a;
  logic           client_b;
  logic [6:0]     minutes_left;
  logic           active;
  logic           expired;
  logic           code_error;
  logic           busy;

  logic           parity_ok;
  logic           word_valid;
  logic [6:0]     word_minutes;

`ifdef BARCODE_READER_PARITY_EN
  assign parity_ok = ~^shift_reg[5:1];
`else
  assign parity_ok = 1'b1;
`endif

  // Field decode of the assembled word, consumed only in CHECK
  always_comb begin
    word_minutes = 7'd0;
    case (shift_reg[3:2])
      2'b01:   word_minutes = 7'd30;
      2'b10:   word_minutes = 7'd60;
      2'b11:   word_minutes = 7'd120;
      default: word_minutes = 7'd0;
    endcase
    word_valid = (shift_reg[5:4] == 2'b01 || shift_reg[5:4] == 2'b10)
                 && (shift_reg[3:2] != 2'b00) && shift_reg[0] && parity_ok;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state        <= IDLE;
      shift_reg    <= 6'd0;
      bit_cnt      <= 3'd0;
      timeout_cnt  <= '0;
      tick_cnt     <= '0;
      code_q       <= 6'd0;
      client_a     <= 1'b0;
      client_b     <= 1'b0;
      minutes_left <= 7'd0;
      active       <= 1'b0;
      expired      <= 1'b0;
      code_error   <= 1'b0;
      busy         <= 1'b0;
    end else begin
      code_error <= 1'b0;
      // A start strobe aborts whatever was running, including a live countdown
      if (bus.ScanStart) begin
        state        <= SHIFT;
        busy         <= 1'b1;
        active       <= 1'b0;
        expired      <= 1'b0;
        client_a     <= 1'b0;
        client_b     <= 1'b0;
        minutes_left <= 7'd0;
        timeout_cnt  <= '0;
        if (bus.ScanValid) begin
          shift_reg <= {5'd0, bus.ScanBit};
          bit_cnt   <= 3'd1;
        end else begin
          bit_cnt   <= 3'd0;
        end
      end else begin
        case (state)
          SHIFT: begin
            if (bus.ScanValid) begin
              shift_reg   <= {shift_reg[4:0], bus.ScanBit};
              timeout_cnt <= '0;
              if (bit_cnt == 3'd5) begin
                bit_cnt <= 3'd0;
                state   <= CHECK;
              end else begin
                bit_cnt <= bit_cnt + 3'd1;
              end
            end else if (timeout_cnt == TO_LAST) begin
              code_error <= 1'b1;
              busy       <= 1'b0;
              state      <= IDLE;
            end else begin
              timeout_cnt <= timeout_cnt + 1'b1;
            end
          end
          CHECK: begin
            code_q <= shift_reg;
            busy   <= 1'b0;
            if (word_valid) begin
              client_a     <= (shift_reg[5:4] == 2'b01);
              client_b     <= (shift_reg[5:4] == 2'b10);
              minutes_left <= word_minutes;
              tick_cnt     <= '0;
              active       <= 1'b1;
              state        <= RUN;
            end else begin
              code_error <= 1'b1;
              state      <= IDLE;
            end
          end
          RUN: begin
            if (tick_cnt == TICK_LAST) begin
              tick_cnt <= '0;
              if (minutes_left == 7'd1) begin
                minutes_left <= 7'd0;
                active       <= 1'b0;
                expired      <= 1'b1;
                state        <= EXPIRED;
              end else begin
                minutes_left <= minutes_left - 7'd1;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.Code        = code_q;
  assign bus.ClientA     = client_a;
  assign bus.ClientB     = client_b;
  assign bus.MinutesLeft = minutes_left;
  assign bus.Active      = active;
  assign bus.Expired     = expired;
  assign bus.CodeError   = code_error;
  assign bus.Busy        = busy;

endmodule

// File: tb/tb_barcode_reader.sv
// Randomized self-checking bench for barcode_reader against a field-level ticket model.
// Honours BARCODE_READER_PARITY_EN the same way the design does.
module tb_barcode_reader;

  localparam int TPM = 4;
  localparam int BTO = 20;

  logic clk = 1'b0;
  logic reset;
  int   assertCount = 0;
  int   failCount   = 0;
  int   lastCode    = 0;
  bit   running     = 0;

  barcode_reader_if bus ();

  barcode_reader #(.TICKS_PER_MIN(TPM), .BIT_TIMEOUT(BTO)) dut (
    .Clk   (clk),
    .Reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Ticket rules written directly from the code-format table
  function automatic void refDecode(input int code, output bit ok, output bit isA,
                                    output bit isB, output int mins);
    int client, dur, ones;
    client = code / 16;
    dur    = (code / 4) % 4;
    ones   = 0;
    for (int i = 1; i <= 5; i++) ones += (code >> i) & 1;
    isA  = (client == 1);
    isB  = (client == 2);
    mins = (dur == 3) ? 120 : dur * 30;
    ok   = (isA || isB) && (dur != 0) && (code % 2 == 1);
`ifdef BARCODE_READER_PARITY_EN
    if (ones % 2 != 0) ok = 0;
`endif
  endfunction

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_code"}, bus.Code, 0);
    checkOutput({tag, "_clienta"}, bus.ClientA, 0);
    checkOutput({tag, "_clientb"}, bus.ClientB, 0);
    checkOutput({tag, "_minutes"}, bus.MinutesLeft, 0);
    checkOutput({tag, "_active"}, bus.Active, 0);
    checkOutput({tag, "_expired"}, bus.Expired, 0);
    checkOutput({tag, "_codeerror"}, bus.CodeError, 0);
    checkOutput({tag, "_busy"}, bus.Busy, 0);
  endtask

  task automatic sendFrame(input logic [5:0] code, input int maxGap);
    int gap;
    @(negedge clk);
    bus.ScanStart = 1; bus.ScanValid = 1; bus.ScanBit = code[5];
    for (int i = 4; i >= 0; i--) begin
      @(negedge clk);
      if (i == 4 && running) begin
        checkOutput("start_drop_active", bus.Active, 0);
        checkOutput("start_clear_minutes", bus.MinutesLeft, 0);
        checkOutput("start_busy", bus.Busy, 1);
      end
      bus.ScanStart = 0;
      bus.ScanValid = 0;
      gap = $urandom_range(0, maxGap);
      repeat (gap) @(negedge clk);
      bus.ScanValid = 1; bus.ScanBit = code[i];
    end
    @(negedge clk);
    bus.ScanValid = 0; bus.ScanBit = 0;
    checkOutput("check_busy", bus.Busy, 1);
  endtask

  task automatic applyStimulus(input logic [5:0] code, input int maxGap, input bit checkExpiry);
    bit ok, isA, isB;
    int mins, total, probe, cycles;
    refDecode(int'(code), ok, isA, isB, mins);
    sendFrame(code, maxGap);
    @(negedge clk);
    lastCode = int'(code);
    checkOutput("code", bus.Code, lastCode);
    checkOutput("codeerror", bus.CodeError, !ok);
    checkOutput("busy_done", bus.Busy, 0);
    checkOutput("active", bus.Active, ok);
    checkOutput("clienta", bus.ClientA, ok && isA);
    checkOutput("clientb", bus.ClientB, ok && isB);
    checkOutput("minutes", bus.MinutesLeft, ok ? mins : 0);
    checkOutput("expired_clear", bus.Expired, 0);
    running = ok;
    if (!ok) begin
      @(negedge clk);
      checkOutput("codeerror_single", bus.CodeError, 0);
      checkOutput("reject_active", bus.Active, 0);
    end else if (checkExpiry) begin
      total  = mins * TPM;
      probe  = $urandom_range(1, total - 1);
      cycles = 0;
      while (bus.Active === 1'b1 && cycles < total + 10) begin
        @(negedge clk);
        cycles++;
        if (cycles == probe)
          checkOutput("mid_minutes", bus.MinutesLeft, mins - probe / TPM);
      end
      checkOutput("expiry_cycles", cycles, total);
      checkOutput("expired_set", bus.Expired, 1);
      checkOutput("expired_minutes", bus.MinutesLeft, 0);
      checkOutput("expired_clienta_hold", bus.ClientA, isA);
      checkOutput("expired_clientb_hold", bus.ClientB, isB);
      running = 0;
    end
  endtask

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [5:0] code;
    logic [1:0] cl, du;
    reset = 1; bus.ScanStart = 0; bus.ScanValid = 0; bus.ScanBit = 0;
    repeat (3) @(negedge clk);
    checkResetState("reset");
    reset = 0;

    applyStimulus(6'h15, 0, 1);
    applyStimulus(6'h19, 2, 0);
    applyStimulus(6'h2F, 1, 1);
    applyStimulus(6'h19, 0, 0);
    applyStimulus(6'h1B, 0, 0);
    applyStimulus(6'h35, 1, 0);
    applyStimulus(6'h18, 0, 0);

    // Stray ScanValid while idle must not start a frame
    @(negedge clk);
    bus.ScanValid = 1; bus.ScanBit = 1;
    repeat (3) @(negedge clk);
    bus.ScanValid = 0;
    @(negedge clk);
    checkOutput("idle_ignore_busy", bus.Busy, 0);
    checkOutput("idle_ignore_code", bus.Code, lastCode);

    // Three bits, then silence until the inter-bit timeout fires
    @(negedge clk);
    bus.ScanStart = 1; bus.ScanValid = 1; bus.ScanBit = 0;
    @(negedge clk);
    bus.ScanStart = 0; bus.ScanBit = 1;
    @(negedge clk);
    bus.ScanBit = 0;
    @(negedge clk);
    bus.ScanValid = 0;
    repeat (BTO - 1) @(negedge clk);
    checkOutput("timeout_early_busy", bus.Busy, 1);
    checkOutput("timeout_early_err", bus.CodeError, 0);
    @(negedge clk);
    checkOutput("timeout_err", bus.CodeError, 1);
    checkOutput("timeout_busy", bus.Busy, 0);
    checkOutput("timeout_code_hold", bus.Code, lastCode);
    running = 0;

    for (int n = 0; n < 20; n++) begin
      if ($urandom_range(0, 1) == 1) begin
        code = 6'($urandom_range(0, 63));
      end else begin
        cl   = 2'($urandom_range(1, 2));
        du   = 2'($urandom_range(1, 3));
        code = {cl, du, ^{cl, du}, 1'b1};
      end
      applyStimulus(code, 3, $urandom_range(0, 2) == 0);
    end

    applyStimulus(6'h2F, 0, 0);
    repeat (17) @(negedge clk);
    reset = 1;
    @(negedge clk);
    checkResetState("midrun_reset");
    reset = 0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
